digit_score_collect: RTL

//  Producer side of the digit_decode interface. Accepts the 10 output-layer neuron scores as a

---
 rtl/digit_score_collect.sv | 59 +++++
 1 files changed

// File: rtl/digit_score_collect.sv
// digit_score_collect: gathers ten serial neuron scores, quantises them to 4 bits and hands the packed vector to digit_decode
module digit_score_collect #(
  parameter int SCORE_W = 16,
  parameter int SHIFT = 8,
  parameter int DECODE_CYCLES = 11
) (
  input  logic clk,
  input  logic n_rst,
  input  logic score_valid,
  input  logic [SCORE_W-1:0] score_data,
  input  logic score_last,
  output logic score_ready,
  output logic [0:9][3:0] digit_weights,
  output logic network_done,
  output logic frame_error,
  output logic busy
);
  localparam int CW = $clog2(DECODE_CYCLES + 1);
  typedef enum logic [1:0] {COLLECT, DONE, HOLD} state_t;
  state_t state, state_n;
  logic [3:0] idx;
  logic [CW-1:0] hold_cnt;
  logic [SCORE_W-1:0] shifted;
  logic [3:0] q;
  logic xfer, at_last, mismatch;
  assign shifted = $signed(score_data) >>> SHIFT;
  // negative scores clamp to 0, anything above 15 after the shift saturates
  assign q = score_data[SCORE_W-1] ? 4'd0 : (|shifted[SCORE_W-1:4]) ? 4'd15 : shifted[3:0];
  assign score_ready = state == COLLECT;
  assign network_done = state == DONE;
  assign busy = state == DONE || state == HOLD;
  assign xfer = score_valid && score_ready;
  assign at_last = idx == 4'd9;
  assign mismatch = at_last != score_last;
  always_comb begin
    state_n = state;
    state_n = (state == DONE) ? HOLD :
              (state == HOLD) ? ((hold_cnt == '0) ? COLLECT : HOLD) :
              (xfer && at_last && score_last) ? DONE : COLLECT;
  end
  always_ff @(posedge clk)
    if (!n_rst) begin
      state <= COLLECT;
      idx <= '0;
      hold_cnt <= '0;
      digit_weights <= '0;
      frame_error <= 1'b0;
    end else begin
      state <= state_n;
      frame_error <= xfer && mismatch;
      if (state == DONE) hold_cnt <= CW'(DECODE_CYCLES - 1);
      else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      if (xfer) begin
        idx <= (mismatch || at_last) ? 4'd0 : idx + 4'd1;
        if (mismatch) digit_weights <= '0;
        else digit_weights[idx] <= q;
      end
    end
endmodule
